// File: rtl/irq_pending_ctrl_pkg.sv
// Shared definitions for the pending-interrupt controller: line count, id width
// and FSM state encodings.
package irq_pending_ctrl_pkg;

    localparam int unsigned NumLines = 4;
    localparam int unsigned IdWidth  = 2;

    typedef logic [NumLines-1:0] line_vec_t;
    typedef logic [IdWidth-1:0]  line_id_t;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StPresent = 2'd1;
    localparam logic [1:0] StRecover = 2'd2;

    function automatic line_vec_t id_to_onehot(line_id_t id);
        return line_vec_t'(1) << id;
    endfunction

endpackage

// File: rtl/four_two_pe.sv
// 4-to-2 fixed-priority encoder: bit 3 wins, returns 0 when no bit is set.
module four_two_pe (
    input  logic [3:0] data,
    output logic [1:0] idx
);

    always_comb begin
        idx = 2'd0;
        if (data[3]) begin
            idx = 2'd3;
        end else if (data[2]) begin
            idx = 2'd2;
        end else if (data[1]) begin
            idx = 2'd1;
        end else if (data[0]) begin
            idx = 2'd0;
        end
    end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Sticky pending-interrupt capture with fixed-priority presentation over a
// valid/ack handshake; one request served per handshake, no preemption.
module irq_pending_ctrl
    import irq_pending_ctrl_pkg::*;
#(
    parameter int unsigned EDGE_MODE = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NumLines-1:0] req,
    input  logic [NumLines-1:0] mask,
    input  logic                irq_ack,
    output logic                irq_valid,
    output logic [IdWidth-1:0]  irq_id,
    output logic [NumLines-1:0] pending,
    output logic [NumLines-1:0] overflow
);

    line_vec_t  req_q;
    line_vec_t  pending_q, pending_d;
    line_vec_t  overflow_q, overflow_d;
    line_vec_t  evt;
    line_vec_t  eligible;
    line_vec_t  ack_clr;
    logic       armed_q;
    logic [1:0] state_q, state_d;
    line_id_t   id_q, id_d;
    line_id_t   pe_idx;
    logic       any_eligible;
    logic       ack_fire;

    // armed_q blocks the first clock after reset, so a line already high is not an edge
    always_comb begin
        if (EDGE_MODE != 0) begin
            evt = req & ~req_q & {NumLines{armed_q}};
        end else begin
            evt = req;
        end
    end

    assign ack_fire = (state_q == StPresent) && irq_ack;
    assign ack_clr  = ack_fire ? id_to_onehot(id_q) : '0;

    // A new event on the line being acknowledged keeps it pending without flagging overflow
    always_comb begin
        pending_d = (pending_q & ~ack_clr) | evt;
        if (EDGE_MODE != 0) begin
            overflow_d = (overflow_q | (evt & pending_q)) & ~ack_clr;
        end else begin
            overflow_d = overflow_q & ~ack_clr;
        end
    end

    assign eligible     = pending_q & ~mask;
    assign any_eligible = |eligible;

    four_two_pe u_pe (
        .data (eligible),
        .idx  (pe_idx)
    );

    // RECOVER is the single non-presenting cycle after an ack; it may launch the next one
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        unique case (state_q)
            StIdle, StRecover: begin
                if (any_eligible) begin
                    state_d = StPresent;
                    id_d    = pe_idx;
                end else begin
                    state_d = StIdle;
                end
            end
            StPresent: begin
                if (irq_ack) begin
                    state_d = StRecover;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            id_q       <= '0;
            req_q      <= '0;
            armed_q    <= 1'b0;
            pending_q  <= '0;
            overflow_q <= '0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            req_q      <= req;
            armed_q    <= 1'b1;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign irq_valid = (state_q == StPresent);
    assign irq_id    = id_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Bench for irq_pending_ctrl: an edge-mode and a level-mode instance checked each
// cycle against a behavioural model, plus directed literal expectations.
module tb_irq_pending_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_e, mask_e, req_l, mask_l;
    logic       ack_e, ack_l;
    logic       valid_e, valid_l;
    logic [1:0] id_e, id_l;
    logic [3:0] pend_e, pend_l, ovf_e, ovf_l;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    irq_pending_ctrl #(.EDGE_MODE(1)) u_dut_edge (
        .clk       (clk),
        .rst       (rst),
        .req       (req_e),
        .mask      (mask_e),
        .irq_ack   (ack_e),
        .irq_valid (valid_e),
        .irq_id    (id_e),
        .pending   (pend_e),
        .overflow  (ovf_e)
    );

    irq_pending_ctrl #(.EDGE_MODE(0)) u_dut_level (
        .clk       (clk),
        .rst       (rst),
        .req       (req_l),
        .mask      (mask_l),
        .irq_ack   (ack_l),
        .irq_valid (valid_l),
        .irq_id    (id_l),
        .pending   (pend_l),
        .overflow  (ovf_l)
    );

    // Behavioural model: index 0 = edge instance, 1 = level instance
    logic [3:0] m_pend  [2];
    logic [3:0] m_ovf   [2];
    logic [3:0] m_prev  [2];
    logic       m_valid [2];
    logic [1:0] m_id    [2];
    logic       m_armed [2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_pend[m]  = 4'd0;
            m_ovf[m]   = 4'd0;
            m_prev[m]  = 4'd0;
            m_valid[m] = 1'b0;
            m_id[m]    = 2'd0;
            m_armed[m] = 1'b0;
        end
    endtask

    task automatic model_step(input int m, input bit edge_mode, input logic [3:0] r,
                              input logic [3:0] mk, input logic a);
        logic [3:0] old_pend;
        logic       served;
        logic       ev;
        old_pend = m_pend[m];
        served   = m_valid[m] && a;
        for (int i = 0; i < 4; i++) begin
            ev = edge_mode ? (r[i] && !m_prev[m][i] && m_armed[m]) : r[i];
            if (served && m_id[m] == i) begin
                m_ovf[m][i]  = 1'b0;
                m_pend[m][i] = ev;
            end else begin
                if (edge_mode && ev && m_pend[m][i]) m_ovf[m][i] = 1'b1;
                if (ev) m_pend[m][i] = 1'b1;
            end
        end
        if (m_valid[m]) begin
            if (a) m_valid[m] = 1'b0;
        end else begin
            for (int i = 3; i >= 0; i--) begin
                if (!m_valid[m] && old_pend[i] && !mk[i]) begin
                    m_valid[m] = 1'b1;
                    m_id[m]    = 2'(i);
                end
            end
        end
        m_prev[m]  = r;
        m_armed[m] = 1'b1;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_reset();
            end else begin
                model_step(0, 1'b1, req_e, mask_e, ack_e);
                model_step(1, 1'b0, req_l, mask_l, ack_l);
            end
        end
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            check("edge.valid", {3'b0, valid_e}, {3'b0, m_valid[0]});
            if (m_valid[0]) check("edge.id", {2'b0, id_e}, {2'b0, m_id[0]});
            check("edge.pending", pend_e, m_pend[0]);
            check("edge.overflow", ovf_e, m_ovf[0]);
            check("level.valid", {3'b0, valid_l}, {3'b0, m_valid[1]});
            if (m_valid[1]) check("level.id", {2'b0, id_l}, {2'b0, m_id[1]});
            check("level.pending", pend_l, m_pend[1]);
            check("level.overflow", ovf_l, m_ovf[1]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pres(input string name, input logic v, input logic [1:0] v_id,
                            input logic exp_v, input logic [1:0] exp_id);
        check({name, ".valid"}, {3'b0, v}, {3'b0, exp_v});
        if (exp_v) check({name, ".id"}, {2'b0, v_id}, {2'b0, exp_id});
    endtask

    initial begin
        rst    = 1'b1;
        req_e  = 4'd0;
        mask_e = 4'd0;
        ack_e  = 1'b0;
        req_l  = 4'd0;
        mask_l = 4'd0;
        ack_l  = 1'b0;
        tick();
        tick();
        check("reset.valid", {3'b0, valid_e}, 4'd0);
        check("reset.id", {2'b0, id_e}, 4'd0);
        check("reset.pending", pend_e, 4'd0);
        check("reset.overflow", ovf_e, 4'd0);
        rst = 1'b0;
        tick();

        // Single edge, then a higher-priority edge during presentation
        req_e = 4'b0001;
        tick();
        check("single.pend_n1", pend_e, 4'b0001);
        chk_pres("single.n1", valid_e, id_e, 1'b0, 2'd0);
        req_e = 4'b0000;
        tick();
        chk_pres("single.n2", valid_e, id_e, 1'b1, 2'd0);
        req_e = 4'b1000;
        tick();
        req_e = 4'b0000;
        chk_pres("nopreempt", valid_e, id_e, 1'b1, 2'd0);
        check("nopreempt.pend", pend_e, 4'b1001);
        ack_e = 1'b1;
        tick();
        ack_e = 1'b0;
        check("single.ack_pend", pend_e, 4'b1000);
        chk_pres("single.recover", valid_e, id_e, 1'b0, 2'd0);
        tick();
        chk_pres("late_hi", valid_e, id_e, 1'b1, 2'd3);
        ack_e = 1'b1;
        tick();
        ack_e = 1'b0;
        check("late_hi.ack_pend", pend_e, 4'b0000);
        tick();
        chk_pres("single.idle", valid_e, id_e, 1'b0, 2'd0);

        // Priority burst
        req_e = 4'b1110;
        tick();
        req_e = 4'b0000;
        check("burst.pend", pend_e, 4'b1110);
        tick();
        for (int k = 3; k >= 1; k--) begin
            chk_pres("burst.present", valid_e, id_e, 1'b1, 2'(k));
            ack_e = 1'b1;
            tick();
            ack_e = 1'b0;
            chk_pres("burst.recover", valid_e, id_e, 1'b0, 2'd0);
            tick();
        end
        chk_pres("burst.idle", valid_e, id_e, 1'b0, 2'd0);
        check("burst.pend_done", pend_e, 4'b0000);

        // Mask, plus a stray ack outside presentation
        mask_e = 4'b1000;
        req_e  = 4'b1001;
        tick();
        req_e = 4'b0000;
        check("mask.pend", pend_e, 4'b1001);
        tick();
        chk_pres("mask.low", valid_e, id_e, 1'b1, 2'd0);
        ack_e = 1'b1;
        tick();
        ack_e = 1'b0;
        check("mask.pend_left", pend_e, 4'b1000);
        tick();
        chk_pres("mask.blocked", valid_e, id_e, 1'b0, 2'd0);
        ack_e = 1'b1;
        tick();
        ack_e = 1'b0;
        check("stray_ack.pend", pend_e, 4'b1000);
        chk_pres("stray_ack", valid_e, id_e, 1'b0, 2'd0);
        mask_e = 4'b0000;
        tick();
        chk_pres("mask.unmasked", valid_e, id_e, 1'b1, 2'd3);
        ack_e = 1'b1;
        tick();
        ack_e = 1'b0;
        tick();
        check("mask.pend_done", pend_e, 4'b0000);

        // Overflow and same-cycle set/clear
        req_e = 4'b0100;
        tick();
        req_e = 4'b0000;
        check("ovf.pend", pend_e, 4'b0100);
        tick();
        chk_pres("ovf.present", valid_e, id_e, 1'b1, 2'd2);
        req_e = 4'b0100;
        tick();
        req_e = 4'b0000;
        check("ovf.flag", ovf_e, 4'b0100);
        chk_pres("ovf.held", valid_e, id_e, 1'b1, 2'd2);
        tick();
        req_e = 4'b0100;
        ack_e = 1'b1;
        tick();
        req_e = 4'b0000;
        ack_e = 1'b0;
        check("setclr.pend", pend_e, 4'b0100);
        check("setclr.ovf", ovf_e, 4'b0000);
        chk_pres("setclr.recover", valid_e, id_e, 1'b0, 2'd0);
        tick();
        chk_pres("setclr.represent", valid_e, id_e, 1'b1, 2'd2);
        ack_e = 1'b1;
        tick();
        ack_e = 1'b0;
        tick();
        check("ovf.pend_done", pend_e, 4'b0000);

        // Reset mid-presentation, req held high through reset
        req_e = 4'b0110;
        tick();
        check("rstmid.pend", pend_e, 4'b0110);
        tick();
        chk_pres("rstmid.present", valid_e, id_e, 1'b1, 2'd2);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid.valid", {3'b0, valid_e}, 4'd0);
        check("rstmid.pend0", pend_e, 4'd0);
        check("rstmid.ovf0", ovf_e, 4'd0);
        tick();
        rst = 1'b0;
        tick();
        check("rstmid.no_edge1", pend_e, 4'd0);
        tick();
        check("rstmid.no_edge2", pend_e, 4'd0);
        chk_pres("rstmid.idle", valid_e, id_e, 1'b0, 2'd0);
        req_e = 4'b0000;
        tick();

        // Level mode: held request re-presented after every ack
        req_l = 4'b0100;
        tick();
        check("level.pend", pend_l, 4'b0100);
        tick();
        chk_pres("level.first", valid_l, id_l, 1'b1, 2'd2);
        for (int k = 0; k < 3; k++) begin
            ack_l = 1'b1;
            tick();
            ack_l = 1'b0;
            chk_pres("level.gap", valid_l, id_l, 1'b0, 2'd0);
            check("level.pend_kept", pend_l, 4'b0100);
            check("level.ovf", ovf_l, 4'b0000);
            tick();
            chk_pres("level.again", valid_l, id_l, 1'b1, 2'd2);
        end
        req_l = 4'b0000;
        ack_l = 1'b1;
        tick();
        ack_l = 1'b0;
        check("level.pend_done", pend_l, 4'b0000);
        tick();
        chk_pres("level.idle", valid_l, id_l, 1'b0, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
